// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller.
package pipe_ctrl_pkg;
  localparam int              REG_ADDR_WIDTH = 5;
  localparam int              ADDR_WIDTH     = 32;
  localparam logic [REG_ADDR_WIDTH-1:0] ZERO_REG = 5'd0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MDU_WAIT = 2'd1,
    FLUSH    = 2'd2
  } state_e;

  // One register-file read port of the instruction sitting in ID.
  typedef struct packed {
    logic                      ren;
    logic [REG_ADDR_WIDTH-1:0] addr;
  } rd_src_t;
endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use comparator: flags an ID read of a register a load in EX is about to write.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  rd_src_t                   src1,
  input  rd_src_t                   src2,
  input  logic                      ex_is_load,
  input  logic                      ex_wen,
  input  logic [REG_ADDR_WIDTH-1:0] ex_write_addr,
  input  logic                      cmp_en,
  output logic                      hazard
);
  logic hit1, hit2;

  assign hit1   = src1.ren && (src1.addr == ex_write_addr);
  assign hit2   = src2.ren && (src2.addr == ex_write_addr);
  // x0 is hardwired, so a load "writing" it never creates a dependency.
  assign hazard = cmp_en && ex_is_load && ex_wen && (ex_write_addr != ZERO_REG) && (hit1 || hit2);
endmodule

// File: rtl/pipe_ctrl.sv
// Hazard/sequencing controller: stall and flush controls for PC, IF/ID and ID/EX.
// Optional MDU watchdog enabled by defining PIPE_CTRL_MDU_TIMEOUT_EN.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int MDU_TIMEOUT  = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      jump_flag_in,
  input  logic [ADDR_WIDTH-1:0]     jump_addr_in,
  input  logic [REG_ADDR_WIDTH-1:0] id_reg1_addr_in,
  input  logic [REG_ADDR_WIDTH-1:0] id_reg2_addr_in,
  input  logic                      id_reg1_ren_in,
  input  logic                      id_reg2_ren_in,
  input  logic                      ex_is_load_in,
  input  logic                      ex_wen_in,
  input  logic [REG_ADDR_WIDTH-1:0] ex_write_addr_in,
  input  logic                      mdu_start_in,
  input  logic                      mdu_done_in,
  input  logic                      hold_req_in,
  output logic                      pc_hold_out,
  output logic                      ifid_hold_out,
  output logic                      ifid_flush_out,
  output logic                      idex_hold_out,
  output logic                      idex_flush_out,
  output logic                      pc_jump_flag_out,
  output logic [ADDR_WIDTH-1:0]     pc_jump_addr_out,
  output logic                      busy_out
`ifdef PIPE_CTRL_MDU_TIMEOUT_EN
  ,output logic                     mdu_timeout_err_out
`endif
);
  localparam logic       MULTI_FLUSH = (FLUSH_CYCLES > 1);
  localparam logic [3:0] FLUSH_INIT  = 4'(FLUSH_CYCLES - 1);

  state_e     state, state_n;
  logic [3:0] cnt, cnt_n;
  logic       hazard;
  logic       pc_hold, ifid_hold, ifid_flush, idex_hold, idex_flush, jmp;
  logic [ADDR_WIDTH-1:0] jmp_addr;

  hazard_detect u_hazard (
    .src1          ('{ren: id_reg1_ren_in, addr: id_reg1_addr_in}),
    .src2          ('{ren: id_reg2_ren_in, addr: id_reg2_addr_in}),
    .ex_is_load    (ex_is_load_in),
    .ex_wen        (ex_wen_in),
    .ex_write_addr (ex_write_addr_in),
    .cmp_en        (1'b1),
    .hazard        (hazard)
  );

`ifdef PIPE_CTRL_MDU_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(MDU_TIMEOUT - 1);
  logic [7:0] mdu_cnt;
  logic       to_err, to_fire;

  assign to_fire = (state == MDU_WAIT) && !mdu_done_in && (mdu_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      mdu_cnt <= '0;
      to_err  <= 1'b0;
    end else begin
      if (state != MDU_WAIT) mdu_cnt <= '0;
      else                   mdu_cnt <= mdu_cnt + 8'd1;
      if (to_fire) to_err <= 1'b1;
    end
  end

  assign mdu_timeout_err_out = to_err && !rst;
`else
  logic to_fire;
  assign to_fire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    pc_hold    = 1'b0;
    ifid_hold  = 1'b0;
    ifid_flush = 1'b0;
    idex_hold  = 1'b0;
    idex_flush = 1'b0;
    jmp        = 1'b0;
    jmp_addr   = '0;
    case (state)
      RUN: begin
        if (jump_flag_in) begin
          jmp        = 1'b1;
          jmp_addr   = jump_addr_in;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          if (MULTI_FLUSH) begin
            state_n = FLUSH;
            cnt_n   = FLUSH_INIT;
          end
        end else if (mdu_start_in) begin
          {pc_hold, ifid_hold, idex_hold} = 3'b111;
          state_n = MDU_WAIT;
        end else if (hazard) begin
          // Freeze the consumer in ID and drop one bubble into EX.
          pc_hold    = 1'b1;
          ifid_hold  = 1'b1;
          idex_flush = 1'b1;
        end else if (hold_req_in) begin
          {pc_hold, ifid_hold, idex_hold} = 3'b111;
        end
      end
      MDU_WAIT: begin
        if (mdu_done_in || to_fire) state_n = RUN;
        else {pc_hold, ifid_hold, idex_hold} = 3'b111;
      end
      FLUSH: begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        cnt_n      = cnt - 4'd1;
        if (cnt == 4'd1) state_n = RUN;
      end
      default: state_n = RUN;
    endcase
  end

  // Flush wins over hold on the same stage; everything is quiet during reset.
  assign pc_hold_out      = !rst && pc_hold;
  assign ifid_flush_out   = !rst && ifid_flush;
  assign ifid_hold_out    = !rst && ifid_hold && !ifid_flush;
  assign idex_flush_out   = !rst && idex_flush;
  assign idex_hold_out    = !rst && idex_hold && !idex_flush;
  assign pc_jump_flag_out = !rst && jmp;
  assign pc_jump_addr_out = rst ? '0 : jmp_addr;
  assign busy_out         = !rst && (state != RUN);
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl; output vector order is
// {pc_hold, ifid_hold, ifid_flush, idex_hold, idex_flush, pc_jump_flag, busy}.
module tb_pipe_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        jump_flag_in;
  logic [31:0] jump_addr_in;
  logic [4:0]  id_reg1_addr_in, id_reg2_addr_in, ex_write_addr_in;
  logic        id_reg1_ren_in, id_reg2_ren_in, ex_is_load_in, ex_wen_in;
  logic        mdu_start_in, mdu_done_in, hold_req_in;
  logic        pc_hold_out, ifid_hold_out, ifid_flush_out, idex_hold_out, idex_flush_out;
  logic        pc_jump_flag_out, busy_out;
  logic [31:0] pc_jump_addr_out;
`ifdef PIPE_CTRL_MDU_TIMEOUT_EN
  logic        mdu_timeout_err_out;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.FLUSH_CYCLES(2), .MDU_TIMEOUT(8)) dut (
    .clk              (clk),
    .rst              (rst),
    .jump_flag_in     (jump_flag_in),
    .jump_addr_in     (jump_addr_in),
    .id_reg1_addr_in  (id_reg1_addr_in),
    .id_reg2_addr_in  (id_reg2_addr_in),
    .id_reg1_ren_in   (id_reg1_ren_in),
    .id_reg2_ren_in   (id_reg2_ren_in),
    .ex_is_load_in    (ex_is_load_in),
    .ex_wen_in        (ex_wen_in),
    .ex_write_addr_in (ex_write_addr_in),
    .mdu_start_in     (mdu_start_in),
    .mdu_done_in      (mdu_done_in),
    .hold_req_in      (hold_req_in),
    .pc_hold_out      (pc_hold_out),
    .ifid_hold_out    (ifid_hold_out),
    .ifid_flush_out   (ifid_flush_out),
    .idex_hold_out    (idex_hold_out),
    .idex_flush_out   (idex_flush_out),
    .pc_jump_flag_out (pc_jump_flag_out),
    .pc_jump_addr_out (pc_jump_addr_out),
    .busy_out         (busy_out)
`ifdef PIPE_CTRL_MDU_TIMEOUT_EN
    ,.mdu_timeout_err_out (mdu_timeout_err_out)
`endif
  );

  logic [6:0] outs;
  assign outs = {pc_hold_out, ifid_hold_out, ifid_flush_out, idex_hold_out,
                 idex_flush_out, pc_jump_flag_out, busy_out};

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic idle();
    jump_flag_in = 0; jump_addr_in = '0;
    id_reg1_addr_in = '0; id_reg2_addr_in = '0; ex_write_addr_in = '0;
    id_reg1_ren_in = 0; id_reg2_ren_in = 0; ex_is_load_in = 0; ex_wen_in = 0;
    mdu_start_in = 0; mdu_done_in = 0; hold_req_in = 0;
  endtask

  // Check mid-cycle with current inputs, then advance past the next rising edge.
  task automatic step(input string tag, input logic [6:0] e, input logic [31:0] ea);
    @(negedge clk);
    chk(tag, 32'(outs), 32'(e));
    chk({tag, "_addr"}, pc_jump_addr_out, ea);
    @(posedge clk); #1;
  endtask

  task automatic load_use(input logic [4:0] wa, input logic [4:0] r1, input logic e1,
                          input logic [4:0] r2, input logic e2);
    ex_is_load_in = 1; ex_wen_in = 1; ex_write_addr_in = wa;
    id_reg1_addr_in = r1; id_reg1_ren_in = e1;
    id_reg2_addr_in = r2; id_reg2_ren_in = e2;
  endtask

  initial begin
    idle();
    rst = 1;
    jump_flag_in = 1; jump_addr_in = 32'h55;
    step("rst_quiet", 7'b0000000, 32'h0);
    idle(); rst = 0;
    step("idle", 7'b0000000, 32'h0);

    // Taken jump, two-cycle flush
    jump_flag_in = 1; jump_addr_in = 32'h100;
    step("jmp_c0", 7'b0010110, 32'h100);
    idle();
    step("jmp_c1", 7'b0010101, 32'h0);
    step("jmp_c2", 7'b0000000, 32'h0);

    // Load-use hazards
    load_use(5'd5, 5'd0, 0, 5'd5, 1);
    step("lu_rs2", 7'b1100100, 32'h0);
    idle();
    step("lu_after", 7'b0000000, 32'h0);
    load_use(5'd7, 5'd7, 1, 5'd3, 0);
    step("lu_rs1", 7'b1100100, 32'h0);
    load_use(5'd0, 5'd0, 1, 5'd0, 1);
    step("lu_x0", 7'b0000000, 32'h0);
    load_use(5'd9, 5'd9, 0, 5'd9, 0);
    step("lu_noren", 7'b0000000, 32'h0);
    load_use(5'd9, 5'd9, 1, 5'd1, 0); ex_wen_in = 0;
    step("lu_nowen", 7'b0000000, 32'h0);
    idle();

    // External hold; load-use beats it
    hold_req_in = 1;
    step("hold_req", 7'b1101000, 32'h0);
    load_use(5'd4, 5'd4, 1, 5'd0, 0);
    step("lu_vs_hold", 7'b1100100, 32'h0);
    idle();

    // MDU: start + 9 wait cycles held, released on done
    mdu_start_in = 1;
    load_use(5'd4, 5'd4, 1, 5'd0, 0);
    step("mdu_start", 7'b1101000, 32'h0);
    idle();
    for (int i = 1; i <= 9; i++) begin
      if (i == 5) begin jump_flag_in = 1; jump_addr_in = 32'h200; hold_req_in = 1; end
      step($sformatf("mdu_w%0d", i), 7'b1101001, 32'h0);
      idle();
    end
    mdu_done_in = 1;
    step("mdu_done", 7'b0000001, 32'h0);
    idle();
    step("mdu_after", 7'b0000000, 32'h0);
    mdu_done_in = 1;
    step("done_in_run", 7'b0000000, 32'h0);
    idle();

    // Jump beats hazard and hold; FLUSH ignores an MDU start
    jump_flag_in = 1; jump_addr_in = 32'hCAFE_0004; hold_req_in = 1;
    load_use(5'd6, 5'd6, 1, 5'd0, 0);
    step("prio_jmp", 7'b0010110, 32'hCAFE_0004);
    idle(); mdu_start_in = 1; hold_req_in = 1;
    step("flush_ign", 7'b0010101, 32'h0);
    idle();
    step("prio_after", 7'b0000000, 32'h0);

    // Reset mid-MDU_WAIT
    mdu_start_in = 1;
    step("rst_mdu_s", 7'b1101000, 32'h0);
    idle();
    step("rst_mdu_w", 7'b1101001, 32'h0);
    rst = 1;
    step("rst_mdu_r", 7'b0000000, 32'h0);
    rst = 0;
    step("rst_mdu_run", 7'b0000000, 32'h0);

`ifdef PIPE_CTRL_MDU_TIMEOUT_EN
    mdu_start_in = 1;
    step("to_start", 7'b1101000, 32'h0);
    idle();
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk); chk($sformatf("to_err_w%0d", i), 32'(mdu_timeout_err_out), 32'h0);
      step($sformatf("to_w%0d", i), 7'b1101001, 32'h0);
    end
    @(negedge clk); chk("to_err_fire", 32'(mdu_timeout_err_out), 32'h0);
    step("to_fire", 7'b0000001, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk($sformatf("to_err_sticky%0d", i), 32'(mdu_timeout_err_out), 32'h1);
      step($sformatf("to_run%0d", i), 7'b0000000, 32'h0);
    end
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk); chk("to_err_clr", 32'(mdu_timeout_err_out), 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
